// File: rtl/hzu.sv
// Hazard detection and stall controller for the 5-stage MIPS pipeline.
// Freezes PC/IF-ID, bubbles ID/EX, and flushes IF/ID on taken control flow.
module hzu #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_useRs,
  input  logic                 id_useRt,
  input  logic                 id_branch,
  input  logic                 id_taken,
  input  logic                 id_mdRead,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_regWrite,
  input  logic                 ex_memRead,
  input  logic                 ex_mdStart,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_memRead,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 stall,
  output logic                 md_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned MD_W   = 5;
  localparam int unsigned HOLD_W = 2;

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [HOLD_W-1:0] n_need, n_rem, hold_dec;
  logic [MD_W-1:0]   md_cnt;
  logic              hit_ex, hit_mem, md_stall;

  // Stall cycles required by the instructions currently in ID/EX/MEM
  always_comb begin
    n_need  = '0;
    hit_ex  = (ex_rd != 5'd0) &&
              ((id_useRs && (id_rs == ex_rd)) || (id_useRt && (id_rt == ex_rd)));
    hit_mem = (mem_rd != 5'd0) &&
              ((id_useRs && (id_rs == mem_rd)) || (id_useRt && (id_rt == mem_rd)));
    if (hit_ex && ex_memRead)
      n_need = 2'd1;
    if (id_branch && hit_ex && ex_regWrite && !ex_memRead)
      n_need = 2'd1;
    if (id_branch && hit_mem && mem_memRead)
      n_need = 2'd1;
    if (id_branch && hit_ex && ex_memRead)
      n_need = 2'd2;
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = id_mdRead && (md_busy || ex_mdStart);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      hold_cnt     <= '0;
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      if (ex_mdStart)
        md_cnt <= MD_W'(MD_LATENCY - 1);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - MD_W'(1);
      if (stall)
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_flush = 1'b0;
    ifid_flush = 1'b0;
    n_rem      = (n_need != '0) ? (n_need - HOLD_W'(1)) : '0;
    hold_dec   = (hold_cnt != '0) ? (hold_cnt - HOLD_W'(1)) : '0;

    case (state)
      RUN: begin
        if (n_need != '0) begin
          hold_next  = n_rem;
          state_next = (n_rem != '0) ? HOLD : RUN;
        end
      end
      HOLD: begin
        // A newly seen hazard can only extend the remaining hold, never shorten it
        hold_next  = (n_rem > hold_dec) ? n_rem : hold_dec;
        state_next = (hold_next != '0) ? HOLD : RUN;
      end
      default: begin
        state_next = RUN;
        hold_next  = '0;
      end
    endcase

    stall      = (state == HOLD) || (n_need != '0) || md_stall;
    pc_write   = !stall;
    ifid_write = !stall;
    idex_flush = stall;
    ifid_flush = id_taken && !stall;
  end

endmodule

// File: tb/tb_hzu.sv
// Self-checking bench for hzu: directed scenarios plus randomized traffic
// compared against a cycle-count model of the pipeline hazard rules.
module tb_hzu;

  localparam int unsigned MD_LATENCY = 4;
  localparam int unsigned CNT_WIDTH  = 32;

  logic clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_useRs, id_useRt, id_branch, id_taken, id_mdRead;
  logic ex_regWrite, ex_memRead, ex_mdStart, mem_memRead;
  logic pc_write, ifid_write, ifid_flush, idex_flush, stall, md_busy;
  logic [CNT_WIDTH-1:0] stall_cycles;

  int vectors = 0;
  int errors  = 0;

  // Reference model: committed extra stall cycles, MD cycles left, stall count
  int m_pending = 0;
  int m_md = 0;
  logic [CNT_WIDTH-1:0] m_cnt = '0;

  hzu #(.MD_LATENCY(MD_LATENCY), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
    .id_branch(id_branch), .id_taken(id_taken), .id_mdRead(id_mdRead),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_mdStart(ex_mdStart), .mem_rd(mem_rd), .mem_memRead(mem_memRead),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall(stall), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((id_useRs && id_rs == r) || (id_useRt && id_rt == r));
  endfunction

  function automatic int need_f();
    int n = 0;
    if (ex_memRead && reads(ex_rd)) n = 1;
    if (id_branch && ex_regWrite && !ex_memRead && reads(ex_rd)) n = 1;
    if (id_branch && mem_memRead && reads(mem_rd) && n < 1) n = 1;
    if (id_branch && ex_memRead && reads(ex_rd)) n = 2;
    return n;
  endfunction

  function automatic bit exp_stall();
    return (m_pending > 0) || (need_f() > 0) || (id_mdRead && (m_md > 0 || ex_mdStart));
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge
  task automatic tick();
    bit s;
    int n;
    @(posedge clk);
    s = exp_stall();
    n = need_f();
    if (!rst_n) begin
      m_pending = 0; m_md = 0; m_cnt = '0;
    end else begin
      if (s) m_cnt = m_cnt + 1;
      if (ex_mdStart) m_md = MD_LATENCY - 1;
      else if (m_md > 0) m_md = m_md - 1;
      m_pending = m_pending - 1;
      if (n - 1 > m_pending) m_pending = n - 1;
      if (m_pending < 0) m_pending = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_useRs = 0; id_useRt = 0; id_branch = 0;
    id_taken = 0; id_mdRead = 0; ex_rd = 0; ex_regWrite = 0; ex_memRead = 0;
    ex_mdStart = 0; mem_rd = 0; mem_memRead = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      errors++; $display("FAIL reset_enables: pc_write=%b ifid_write=%b required 1 1", pc_write, ifid_write);
    end
    vectors++;
    if (ifid_flush !== 1'b0 || idex_flush !== 1'b0 || stall !== 1'b0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ifid_flush=%b idex_flush=%b stall=%b md_busy=%b required 0 0 0 0",
                         ifid_flush, idex_flush, stall, md_busy);
    end
    vectors++;
    if (stall_cycles !== 0) begin
      errors++; $display("FAIL reset_count: stall_cycles=%0d required 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_rd = 8; ex_memRead = 1; ex_regWrite = 1; id_rs = 8; id_useRs = 1;
    #2;
    vectors++;
    if (stall !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0 || idex_flush !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: stall=%b pc_write=%b ifid_write=%b idex_flush=%b required 1 0 0 1",
                         stall, pc_write, ifid_write, idex_flush);
    end
    tick();
    ex_rd = 0; ex_memRead = 0; ex_regWrite = 0;
    mem_rd = 8; mem_memRead = 1;
    #2;
    vectors++;
    if (stall !== 1'b0 || pc_write !== 1'b1 || stall_cycles !== 1) begin
      errors++; $display("FAIL load_use_release: stall=%b pc_write=%b stall_cycles=%0d required 0 1 1",
                         stall, pc_write, stall_cycles);
    end
  endtask

  task automatic test_branch_load();
    do_reset();
    id_branch = 1; id_rs = 8; id_useRs = 1; ex_rd = 8; ex_memRead = 1; ex_regWrite = 1;
    #2;
    vectors++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL branch_load_c1: stall=%b required 1", stall);
    end
    tick();
    ex_rd = 0; ex_memRead = 0; ex_regWrite = 0; mem_rd = 8; mem_memRead = 1;
    #2;
    vectors++;
    if (stall !== 1'b1 || pc_write !== 1'b0) begin
      errors++; $display("FAIL branch_load_c2: stall=%b pc_write=%b required 1 0", stall, pc_write);
    end
    tick();
    mem_rd = 0; mem_memRead = 0;
    #2;
    vectors++;
    if (stall !== 1'b0 || pc_write !== 1'b1 || stall_cycles !== 2) begin
      errors++; $display("FAIL branch_load_release: stall=%b pc_write=%b stall_cycles=%0d required 0 1 2",
                         stall, pc_write, stall_cycles);
    end
  endtask

  task automatic test_branch_alu();
    do_reset();
    id_branch = 1; id_rs = 9; id_useRs = 1; ex_rd = 9; ex_regWrite = 1;
    #2;
    vectors++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL branch_alu_stall: stall=%b required 1", stall);
    end
    tick();
    ex_rd = 0; ex_regWrite = 0; mem_rd = 9;
    #2;
    vectors++;
    if (stall !== 1'b0 || stall_cycles !== 1) begin
      errors++; $display("FAIL branch_alu_release: stall=%b stall_cycles=%0d required 0 1", stall, stall_cycles);
    end
    tick();
    // Register 0 on both sides must never match
    mem_rd = 0; id_rs = 0; id_rt = 9; id_useRt = 1; ex_rd = 0; ex_regWrite = 1; ex_memRead = 1;
    mem_memRead = 1;
    #2;
    vectors++;
    if (stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++; $display("FAIL branch_r0: stall=%b pc_write=%b required 0 1", stall, pc_write);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_md();
    do_reset();
    ex_mdStart = 1; id_mdRead = 1;
    #2;
    vectors++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      errors++; $display("FAIL md_issue: stall=%b md_busy=%b required 1 0", stall, md_busy);
    end
    tick();
    ex_mdStart = 0;
    for (int k = 1; k <= 3; k++) begin
      #2;
      vectors++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        errors++; $display("FAIL md_busy_c%0d: stall=%b md_busy=%b required 1 1", k, stall, md_busy);
      end
      tick();
    end
    #2;
    vectors++;
    if (stall !== 1'b0 || md_busy !== 1'b0 || pc_write !== 1'b1 || stall_cycles !== 4) begin
      errors++; $display("FAIL md_release: stall=%b md_busy=%b pc_write=%b stall_cycles=%0d required 0 0 1 4",
                         stall, md_busy, pc_write, stall_cycles);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_taken();
    do_reset();
    id_taken = 1;
    #2;
    vectors++;
    if (ifid_flush !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL taken_plain: ifid_flush=%b stall=%b required 1 0", ifid_flush, stall);
    end
    tick();
    ex_rd = 8; ex_memRead = 1; id_rt = 8; id_useRt = 1;
    #2;
    vectors++;
    if (ifid_flush !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL taken_stalled: ifid_flush=%b stall=%b required 0 1", ifid_flush, stall);
    end
    tick();
    ex_rd = 0; ex_memRead = 0;
    #2;
    vectors++;
    if (ifid_flush !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL taken_after_stall: ifid_flush=%b stall=%b required 1 0", ifid_flush, stall);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    id_branch = 1; id_rs = 8; id_useRs = 1; ex_rd = 8; ex_memRead = 1; ex_regWrite = 1;
    tick();
    ex_rd = 0; ex_memRead = 0; ex_regWrite = 0; mem_rd = 8; mem_memRead = 1;
    ex_mdStart = 1; rst_n = 0;
    tick();
    clear_inputs(); rst_n = 1;
    #2;
    vectors++;
    if (pc_write !== 1'b1 || stall !== 1'b0 || md_busy !== 1'b0 || stall_cycles !== 0) begin
      errors++; $display("FAIL reset_mid_stall: pc_write=%b stall=%b md_busy=%b stall_cycles=%0d required 1 0 0 0",
                         pc_write, stall, md_busy, stall_cycles);
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    bit es;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      id_rs = rnd_reg(); id_rt = rnd_reg(); ex_rd = rnd_reg(); mem_rd = rnd_reg();
      id_useRs = 1'($urandom); id_useRt = 1'($urandom);
      id_branch = ($urandom_range(0, 2) == 0); id_taken = ($urandom_range(0, 3) == 0);
      id_mdRead = ($urandom_range(0, 3) == 0);
      ex_regWrite = 1'($urandom); ex_memRead = ($urandom_range(0, 2) == 0);
      ex_mdStart = (m_md == 0) && ($urandom_range(0, 7) == 0);
      mem_memRead = ($urandom_range(0, 2) == 0);
      #2;
      es = exp_stall();
      vectors++;
      if (stall !== es || pc_write !== !es || ifid_write !== !es || idex_flush !== es) begin
        errors++; $display("FAIL rnd_stall[%0d]: stall=%b pc_write=%b ifid_write=%b idex_flush=%b required stall=%b",
                           i, stall, pc_write, ifid_write, idex_flush, es);
      end
      vectors++;
      if (ifid_flush !== (id_taken && !es)) begin
        errors++; $display("FAIL rnd_flush[%0d]: ifid_flush=%b required %b", i, ifid_flush, id_taken && !es);
      end
      vectors++;
      if (md_busy !== (m_md > 0) || stall_cycles !== m_cnt) begin
        errors++; $display("FAIL rnd_state[%0d]: md_busy=%b stall_cycles=%0d required %b %0d",
                           i, md_busy, stall_cycles, m_md > 0, m_cnt);
      end
      tick();
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_md();
    test_taken();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
